// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor computing a - b. It uses one
//   full-subtractor cell and a borrow flop, and works LSB-first over WIDTH
//   cycles. Operands come in on a valid/ready handshake and the result
//   leaves on another valid/ready handshake.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN. When it is defined, the
//   block adds the output ovf, which is the signed overflow of a - b.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand pair presented
//   in_ready   block can accept operands (asserted only when idle)
//   a, b       minuend / subtrahend, WIDTH bits
//   out_valid  result held on diff/borrow
//   out_ready  consumer accepts result
//   diff       (a - b) mod 2^WIDTH
//   borrow     1 when a < b as unsigned
//   ovf        signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [WIDTH-1:0] diff_q;
  logic             bin, borrow_q;
  logic [CW-1:0]    count;
  logic             last;
  logic             a0, b0, d, bout;

  assign a0   = a_sh[0];
  assign b0   = b_sh[0];
  assign d    = a0 ^ b0 ^ bin;
  assign bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
  assign last = (count == CW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The result goes into a separate output register on the last shift.
  // This keeps diff/borrow stable outside DONE while the working
  // registers are reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      bin      <= 1'b0;
      count    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            bin   <= 1'b0;
            count <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {d, res[WIDTH-1:1]};
          bin   <= bout;
          count <= count + 1'b1;
          if (last) begin
            diff_q   <= {d, res[WIDTH-1:1]};
            borrow_q <= bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last shift, a0 and b0 hold the operand sign bits and d is the
  // sign bit of the difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (state_q == SHIFT && last) ovf_q <= (a0 ^ b0) & (d ^ a0);
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W  = 4;
  localparam int W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, out_valid, out_ready, borrow;
  logic [W-1:0]  a, b, diff;
  logic          in_valid2, in_ready2, out_valid2, out_ready2, borrow2;
  logic [W2-1:0] a2, b2, diff2;
`ifdef SERIAL_SUB_OVF_EN
  logic          ovf, ovf2;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(W2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .diff(diff2), .borrow(borrow2)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf2)
`endif
  );

  int  checks = 0;
  int  errors = 0;
  time acc_t, out_t;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Behavioural model: the phase counts clock edges since acceptance.
  // The expected result is computed with plain integer arithmetic.
  int           phase = 0;
  logic [W-1:0] ed;
  logic         eb, eo;
  int           sa, sb, sd;

  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_diff", 32'(diff), 0);
      chk("rst_borrow", 32'(borrow), 0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(phase == 0));
      chk("out_valid", 32'(out_valid), 32'(phase == W + 1));
      if (phase == W + 1) begin
        chk("diff", 32'(diff), 32'(ed));
        chk("borrow", 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(eo));
`endif
      end
      if (phase == 0) begin
        if (in_valid) begin
          ed = a - b;
          eb = (a < b);
          sa = int'($signed(a));
          sb = int'($signed(b));
          sd = sa - sb;
          eo = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
          phase = 1;
        end
      end else if (phase <= W) begin
        phase++;
      end else if (out_ready) begin
        phase = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
    int n;
    n = 0;
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    chk("accept_timeout", 32'(in_ready), 1);
    acc_t = $time;
    @(posedge clk); #1;
    if (keep) begin a = W'($urandom); b = W'($urandom); end
    else in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin n++; @(negedge clk); end
    chk("out_timeout", 32'(out_valid), 1);
    lat = int'(($time - acc_t) / 10);
    out_t = $time;
  endtask

  initial begin
    int  lat;
    time t_prev_acc, t_prev_out;
    int  n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
    #1;
    chk("init_in_ready", 32'(in_ready), 1);
    chk("init_out_valid", 32'(out_valid), 0);
    @(negedge clk); @(posedge clk); #1 rst = 1'b0;

    // Basic results with hand-computed expectations
    send(4'd9, 4'd3, 1'b0);
    wait_out(lat);
    chk("t1_latency", 32'(lat), 5);
    chk("t1_diff", 32'(diff), 6);
    chk("t1_borrow", 32'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("t1_ovf", 32'(ovf), 1);
`endif
    @(posedge clk); #1;
    send(4'd0, 4'd0, 1'b0);
    wait_out(lat);
    chk("t2_zero_diff", 32'(diff), 0);
    chk("t2_zero_borrow", 32'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("t2_zero_ovf", 32'(ovf), 0);
`endif
    @(posedge clk); #1;
    send(4'd3, 4'd9, 1'b0);
    wait_out(lat);
    chk("t2_diff", 32'(diff), 32'hA);
    chk("t2_borrow", 32'(borrow), 1);
`ifdef SERIAL_SUB_OVF_EN
    chk("t2_ovf", 32'(ovf), 1);
`endif
    @(posedge clk); #1;

    // Reset in the middle of SHIFT
    send(4'd7, 4'd1, 1'b0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("t5_async_in_ready", 32'(in_ready), 1);
    chk("t5_async_out_valid", 32'(out_valid), 0);
    chk("t5_async_diff", 32'(diff), 0);
    chk("t5_async_borrow", 32'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("t5_async_ovf", 32'(ovf), 0);
`endif
    @(negedge clk); @(posedge clk); #1 rst = 1'b0;
    send(4'd6, 4'd6, 1'b0);
    wait_out(lat);
    chk("t5_diff", 32'(diff), 0);
    chk("t5_borrow", 32'(borrow), 0);
    @(posedge clk); #1;

    // Back-pressure
    out_ready = 1'b0;
    send(4'hF, 4'h1, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid), 1);
      chk("t3_hold_diff", 32'(diff), 32'hE);
      chk("t3_hold_borrow", 32'(borrow), 0);
      chk("t3_hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_valid", 32'(out_valid), 1);
    @(negedge clk);
    chk("t3_after_valid", 32'(out_valid), 0);
    chk("t3_after_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high, garbage during SHIFT
    send(4'd5, 4'd2, 1'b1);
    t_prev_acc = acc_t;
    wait_out(lat);
    chk("t4_r1_diff", 32'(diff), 3);
    chk("t4_r1_borrow", 32'(borrow), 0);
    t_prev_out = out_t;
    send(4'd2, 4'd5, 1'b1);
    chk("t4_acc_spacing", 32'((acc_t - t_prev_acc) / 10), 6);
    t_prev_acc = acc_t;
    wait_out(lat);
    chk("t4_r2_diff", 32'(diff), 32'hD);
    chk("t4_r2_borrow", 32'(borrow), 1);
    chk("t4_out_spacing", 32'((out_t - t_prev_out) / 10), 6);
    t_prev_out = out_t;
    send(4'd8, 4'd8, 1'b0);
    chk("t4_acc_spacing2", 32'((acc_t - t_prev_acc) / 10), 6);
    wait_out(lat);
    chk("t4_r3_diff", 32'(diff), 0);
    chk("t4_r3_borrow", 32'(borrow), 0);
    chk("t4_out_spacing2", 32'((out_t - t_prev_out) / 10), 6);
    @(posedge clk); #1;

    // Exhaustive WIDTH=4, checked by the model process
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        send(W'(x), W'(y), 1'b0);
        wait_out(lat);
        chk("ex4_diff", 32'(diff), 32'((x - y) & 15));
        chk("ex4_borrow", 32'(borrow), 32'(x < y));
        @(posedge clk); #1;
      end

    // Random traffic with random stalls
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) begin @(posedge clk); #1; end

    // Exhaustive WIDTH=2 against the 2-bit adder with b negated
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) begin
        a2 = W2'(x); b2 = W2'(y); in_valid2 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready2 && n < 50) begin n++; @(negedge clk); end
        chk("w2_accept_timeout", 32'(in_ready2), 1);
        @(posedge clk); #1 in_valid2 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid2 && n < 50) begin n++; @(negedge clk); end
        chk("w2_out_timeout", 32'(out_valid2), 1);
        chk("w2_latency", 32'(n), 2);
        chk("w2_diff", 32'(diff2), 32'((x + ((4 - y) & 3)) & 3));
        chk("w2_borrow", 32'(borrow2), 32'(x < y));
`ifdef SERIAL_SUB_OVF_EN
        sa = (x > 1) ? x - 4 : x;
        sb = (y > 1) ? y - 4 : y;
        chk("w2_ovf", 32'(ovf2), 32'((sa - sb < -2) || (sa - sb > 1)));
`endif
        @(posedge clk); #1;
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
